full_adder: RTL and testbench

- Parameterised binary adder: sum and carry-out of two WIDTH-bit operands plus a 1-bit carry-in.
- Default WIDTH=1 gives the classic 1-bit full adder used as a leaf arithmetic cell.
- Optional output register stage lets the block sit directly in a clocked datapath.
- One clock domain; synchronous, active-high reset.

---
 rtl/full_adder_pkg.sv | 6 +
 rtl/full_adder_cell.sv | 14 +
 rtl/full_adder.sv | 61 ++++++
 tb/tb_full_adder.sv | 138 +++++++++++++
 4 files changed

// File: rtl/full_adder_pkg.sv
// Shared constants for the adder family; the width bound is checked at elaboration
// by every adder that imports this package.
package full_adder_pkg;
  localparam int FA_MIN_WIDTH = 1;
  localparam int FA_MAX_WIDTH = 64;
endpackage

// File: rtl/full_adder_cell.sv
// 1-bit full adder leaf cell; chained by full_adder to form a ripple-carry adder.
module full_adder_cell (
  input  logic a,
  input  logic b,
  input  logic cin,
  output logic s,
  output logic co
);
  logic p;

  assign p  = a ^ b;
  assign s  = p ^ cin;
  assign co = (a & b) | (cin & p);
endmodule

// File: rtl/full_adder.sv
// WIDTH-bit ripple-carry adder built from full_adder_cell, with an optional
// output register (OUTPUT_REG=1) that has a synchronous active-high reset.
module full_adder
  import full_adder_pkg::*;
#(
  parameter int WIDTH      = 1,
  parameter bit OUTPUT_REG = 1'b0
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  output logic [WIDTH-1:0] sum,
  output logic             cout
);
  if (WIDTH < FA_MIN_WIDTH || WIDTH > FA_MAX_WIDTH) begin : g_width_chk
    $fatal(1, "full_adder: WIDTH=%0d outside %0d..%0d", WIDTH, FA_MIN_WIDTH, FA_MAX_WIDTH);
  end

  logic [WIDTH:0]   c;
  logic [WIDTH-1:0] s_comb;

  assign c[0] = cin;

  for (genvar i = 0; i < WIDTH; i++) begin : g_cell
    full_adder_cell u_cell (
      .a   (a[i]),
      .b   (b[i]),
      .cin (c[i]),
      .s   (s_comb[i]),
      .co  (c[i+1])
    );
  end

  if (OUTPUT_REG) begin : g_oreg
    logic [WIDTH-1:0] sum_q;
    logic             cout_q;

    // Reset wins over the computed result, so an in-flight sum is dropped.
    always_ff @(posedge clk) begin
      if (rst) begin
        sum_q  <= '0;
        cout_q <= 1'b0;
      end else begin
        sum_q  <= s_comb;
        cout_q <= c[WIDTH];
      end
    end

    assign sum  = sum_q;
    assign cout = cout_q;
  end else begin : g_comb
    // clk/rst exist only for port compatibility with the registered variant.
    logic unused_clk_rst;
    assign unused_clk_rst = &{1'b0, clk, rst};

    assign sum  = s_comb;
    assign cout = c[WIDTH];
  end
endmodule

// File: tb/tb_full_adder.sv
// Scoreboard bench for full_adder: four configurations driven together, expected
// {cout,sum} queued at issue time and popped by a negedge monitor when due.
module tb_full_adder;
  logic clk = 1'b0;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // WIDTH=1 combinational
  logic a1 = 0, b1 = 0, ci1 = 0, s1, co1;
  // WIDTH=8 combinational
  logic [7:0] a8 = '0, b8 = '0, s8;
  logic       ci8 = 0, co8;
  // WIDTH=8 registered
  logic [7:0] ar = '0, br = '0, sr;
  logic       cir = 0, cor, rstr = 1'b1;
  // WIDTH=16 combinational
  logic [15:0] a16 = '0, b16 = '0, s16;
  logic        ci16 = 0, co16;

  full_adder #(.WIDTH(1), .OUTPUT_REG(1'b0)) u_w1 (
    .clk(clk), .rst(1'b0), .a(a1), .b(b1), .cin(ci1), .sum(s1), .cout(co1));
  full_adder #(.WIDTH(8), .OUTPUT_REG(1'b0)) u_w8 (
    .clk(clk), .rst(1'b0), .a(a8), .b(b8), .cin(ci8), .sum(s8), .cout(co8));
  full_adder #(.WIDTH(8), .OUTPUT_REG(1'b1)) u_w8r (
    .clk(clk), .rst(rstr), .a(ar), .b(br), .cin(cir), .sum(sr), .cout(cor));
  full_adder #(.WIDTH(16), .OUTPUT_REG(1'b0)) u_w16 (
    .clk(clk), .rst(1'b0), .a(a16), .b(b16), .cin(ci16), .sum(s16), .cout(co16));

  typedef struct {
    int          due;
    logic [16:0] exp;
  } exp_t;

  exp_t q1[$], q8[$], qr[$], q16[$];
  int n_chk  = 0;
  int n_fail = 0;

  task automatic check(input string nm, input logic [16:0] act, input logic [16:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s cyc=%0d actual=%h required=%h", nm, cyc, act, exp);
    end
  endtask

  // Monitor: every negedge, pop whatever expectations have come due.
  always @(negedge clk) begin
    exp_t e;
    while (q1.size() > 0 && q1[0].due <= cyc) begin
      e = q1.pop_front();
      check("w1_comb", 17'({co1, s1}), e.exp);
    end
    while (q8.size() > 0 && q8[0].due <= cyc) begin
      e = q8.pop_front();
      check("w8_comb", 17'({co8, s8}), e.exp);
    end
    while (qr.size() > 0 && qr[0].due <= cyc) begin
      e = qr.pop_front();
      check("w8_reg", 17'({cor, sr}), e.exp);
    end
    while (q16.size() > 0 && q16[0].due <= cyc) begin
      e = q16.pop_front();
      check("w16_comb", 17'({co16, s16}), e.exp);
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Reference model: plain unsigned sum at WIDTH+1 bits.
  function automatic logic [16:0] ref_add(input logic [15:0] x, input logic [15:0] y,
                                          input logic c);
    return 17'(x) + 17'(y) + 17'(c);
  endfunction

  // Registered DUT: inputs applied now are visible after the next edge.
  task automatic drive_reg(input logic r, input logic [7:0] x, input logic [7:0] y,
                           input logic c);
    rstr = r; ar = x; br = y; cir = c;
    qr.push_back('{due: cyc + 1, exp: r ? 17'd0 : ref_add(16'(x), 16'(y), c)});
  endtask

  logic [1:0]  tt[8]  = '{2'b00, 2'b01, 2'b01, 2'b10, 2'b01, 2'b10, 2'b10, 2'b11};
  logic [7:0]  da[4]  = '{8'hFF, 8'hFF, 8'hFF, 8'h3C};
  logic [7:0]  db[4]  = '{8'h01, 8'h00, 8'hFF, 8'h0A};
  logic        dc[4]  = '{1'b0, 1'b1, 1'b1, 1'b0};
  logic [16:0] dexp[4] = '{17'h100, 17'h100, 17'h1FF, 17'h046};

  initial begin
    logic [2:0] v;

    // WIDTH=1 truth-table sweep
    for (int i = 0; i < 8; i++) begin
      tick();
      v = 3'(i);
      {a1, b1, ci1} = v;
      q1.push_back('{due: cyc, exp: 17'(tt[i])});
    end

    // WIDTH=8 combinational boundary vectors
    for (int i = 0; i < 4; i++) begin
      tick();
      a8 = da[i]; b8 = db[i]; ci8 = dc[i];
      q8.push_back('{due: cyc, exp: dexp[i]});
    end

    // Registered: 2-cycle reset, release with full carry, then mid-stream reset
    tick(); drive_reg(1'b1, 8'h80, 8'h80, 1'b1);
    tick(); drive_reg(1'b1, 8'h80, 8'h80, 1'b1);
    tick(); drive_reg(1'b0, 8'h80, 8'h80, 1'b1);
    tick(); drive_reg(1'b0, 8'h12, 8'h34, 1'b0);
    tick(); drive_reg(1'b1, 8'h12, 8'h34, 1'b0);
    tick(); drive_reg(1'b0, 8'h12, 8'h34, 1'b0);

    // Random traffic on all four instances
    for (int n = 0; n < 10000; n++) begin
      tick();
      a16 = 16'($urandom); b16 = 16'($urandom); ci16 = 1'($urandom);
      q16.push_back('{due: cyc, exp: ref_add(a16, b16, ci16)});
      a8 = 8'($urandom); b8 = 8'($urandom); ci8 = 1'($urandom);
      q8.push_back('{due: cyc, exp: ref_add(16'(a8), 16'(b8), ci8)});
      v = 3'($urandom);
      {a1, b1, ci1} = v;
      q1.push_back('{due: cyc, exp: ref_add(16'(v[2]), 16'(v[1]), v[0])});
      drive_reg($urandom_range(0, 15) == 0, 8'($urandom), 8'($urandom), 1'($urandom));
    end

    repeat (3) tick();
    check("scoreboard_drained", 17'(q1.size() + q8.size() + qr.size() + q16.size()), 17'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
